// File: rtl/sentry_release_pkg.sv
// rtl/sentry_release_pkg.sv - shared tag/data types, release entry and alert codes for sentry_release
package sentry_release_pkg;

    localparam int TAG_W  = 8;
    localparam int DATA_W = 32;

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        tag_t  tag;
        data_t data;
    } rel_entry_t;

    typedef enum logic [1:0] {
        ALERT_NONE    = 2'd0,
        ALERT_INVALID = 2'd1,
        ALERT_ORDER   = 2'd2,
        ALERT_TIMEOUT = 2'd3
    } alert_code_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage

// File: rtl/sentry_release_queue.sv
// rtl/sentry_release_queue.sv - first-word-fall-through quarantine FIFO of rel_entry_t
module sentry_release_queue
    import sentry_release_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  rel_entry_t       push_data,
    input  logic             pop,
    output rel_entry_t       head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    rel_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage carries no reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/sentry_release.sv
// rtl/sentry_release.sv - tag-gated release of quarantined host transactions; SENTRY_RELEASE_TIMEOUT_EN adds a stall timeout
module sentry_release
    import sentry_release_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pend_valid,
    input  tag_t       pend_tag,
    input  data_t      pend_data,
    output logic       pend_ready,
    input  tag_t       chk_tag,
    input  logic       chk_tag_valid,
    output logic       chk_tag_clear,
    input  logic       chk_invalid,
    output logic       rel_valid,
    output tag_t       rel_tag,
    output data_t      rel_data,
    input  logic       rel_ready,
    output logic       alert,
    output logic [1:0] alert_code
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    state_t           state;
    state_t           state_nxt;
    alert_code_t      cause;
    alert_code_t      code_q;
    rel_entry_t       pend_entry;
    rel_entry_t       head;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             push;
    logic             pop;
    logic             can_load;
    logic             tag_seen;
    logic             match;
    logic             order_viol;
    logic             invalid_hit;
    logic             timeout_hit;

    assign pend_entry = '{tag: pend_tag, data: pend_data};
    assign empty      = (count == '0);
    assign push       = pend_valid && pend_ready;
    assign can_load   = !rel_valid || rel_ready;

    // An invalid from the checker vetoes a match that lands in the same cycle.
    assign tag_seen    = (state == ST_RUN) && !empty && chk_tag_valid;
    assign invalid_hit = (state == ST_RUN) && chk_invalid;
    assign match       = tag_seen && (chk_tag == head.tag) && can_load && !chk_invalid;
    assign order_viol  = tag_seen && (chk_tag != head.tag);
    assign pop         = match;

    sentry_release_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (pend_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

`ifdef SENTRY_RELEASE_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = 1;

    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (empty || pop) begin
            wait_cnt <= '0;
        end else if (state == ST_RUN) begin
            wait_cnt <= wait_cnt + WAIT_ONE;
        end
    end

    assign timeout_hit = (state == ST_RUN) && !empty && !pop && (wait_cnt == WAIT_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_RUN;
            code_q <= ALERT_NONE;
        end else begin
            state <= state_nxt;
            if (state == ST_RUN) begin
                code_q <= cause;
            end
        end
    end

    always_comb begin
        cause     = ALERT_NONE;
        state_nxt = state;
        if (invalid_hit) begin
            cause = ALERT_INVALID;
        end else if (order_viol) begin
            cause = ALERT_ORDER;
        end else if (timeout_hit) begin
            cause = ALERT_TIMEOUT;
        end
        if ((state == ST_RUN) && (cause != ALERT_NONE)) begin
            state_nxt = ST_HALT;
        end
    end

    always_comb begin
        pend_ready    = 1'b0;
        chk_tag_clear = 1'b0;
        alert         = 1'b0;
        case (state)
            ST_RUN: begin
                pend_ready    = (count != FULL_CNT);
                chk_tag_clear = match;
            end
            ST_HALT: begin
                alert = 1'b1;
            end
            default: begin
                alert = 1'b1;
            end
        endcase
    end

    assign alert_code = code_q;

    // One-entry output stage; in HALT no loads occur but a held entry still drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rel_valid <= 1'b0;
            rel_tag   <= '0;
            rel_data  <= '0;
        end else if (match) begin
            rel_valid <= 1'b1;
            rel_tag   <= head.tag;
            rel_data  <= head.data;
        end else if (rel_valid && rel_ready) begin
            rel_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sentry_release.sv
// tb/tb_sentry_release.sv - scoreboard bench for sentry_release (honours SENTRY_RELEASE_TIMEOUT_EN)
module tb_sentry_release;
    import sentry_release_pkg::*;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pend_valid = 1'b0;
    tag_t       pend_tag = '0;
    data_t      pend_data = '0;
    logic       pend_ready;
    tag_t       chk_tag = '0;
    logic       chk_tag_valid = 1'b0;
    logic       chk_tag_clear;
    logic       chk_invalid = 1'b0;
    logic       rel_valid;
    tag_t       rel_tag;
    data_t      rel_data;
    logic       rel_ready = 1'b0;
    logic       alert;
    logic [1:0] alert_code;

    always #5 clk = ~clk;

    sentry_release #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .pend_valid    (pend_valid),
        .pend_tag      (pend_tag),
        .pend_data     (pend_data),
        .pend_ready    (pend_ready),
        .chk_tag       (chk_tag),
        .chk_tag_valid (chk_tag_valid),
        .chk_tag_clear (chk_tag_clear),
        .chk_invalid   (chk_invalid),
        .rel_valid     (rel_valid),
        .rel_tag       (rel_tag),
        .rel_data      (rel_data),
        .rel_ready     (rel_ready),
        .alert         (alert),
        .alert_code    (alert_code)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    rel_entry_t sb[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Accepted pushes become expectations; every release handshake must match the oldest one.
    always @(negedge clk) begin
        if (!rst) begin
            if (pend_valid && pend_ready) begin
                sb.push_back('{tag: pend_tag, data: pend_data});
            end
            if (rel_valid && rel_ready) begin
                if (sb.size() == 0) begin
                    check("rel_unexpected", 64'd1, 64'd0);
                end else begin
                    rel_entry_t e;
                    e = sb.pop_front();
                    check("rel_tag", 64'(rel_tag), 64'(e.tag));
                    check("rel_data", 64'(rel_data), 64'(e.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pend_valid    = 1'b0;
        chk_tag_valid = 1'b0;
        chk_invalid   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push_one(input tag_t t, input data_t d);
        pend_valid = 1'b1;
        pend_tag   = t;
        pend_data  = d;
        tick();
        pend_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tag_t  nxt_push;
        tag_t  nxt_chk;
        int    n_push;
        int    bad_clear;
        bit    saw_full;

        #3;
        check("rst_pend_ready", 64'(pend_ready), 64'd1);
        check("rst_clear", 64'(chk_tag_clear), 64'd0);
        check("rst_rel_valid", 64'(rel_valid), 64'd0);
        check("rst_rel_tag", 64'(rel_tag), 64'd0);
        check("rst_rel_data", 64'(rel_data), 64'd0);
        check("rst_alert", 64'(alert), 64'd0);
        check("rst_code", 64'(alert_code), 64'd0);
        do_reset();

        // In-order release of 5,6,7
        rel_ready = 1'b1;
        push_one(8'd5, 32'hA);
        push_one(8'd6, 32'hB);
        push_one(8'd7, 32'hC);
        for (int t = 5; t <= 7; t++) begin
            chk_tag_valid = 1'b1;
            chk_tag       = tag_t'(t);
            @(negedge clk);
            check("basic_clear", 64'(chk_tag_clear), 64'd1);
            tick();
            chk_tag_valid = 1'b0;
            @(negedge clk);
            check("basic_rel_valid", 64'(rel_valid), 64'd1);
            check("basic_rel_tag", 64'(rel_tag), 64'(t));
            tick();
        end
        check("basic_alert", 64'(alert), 64'd0);
        check("basic_sb_empty", 64'(sb.size()), 64'd0);
        do_reset();

        // Order violation
        push_one(8'd5, 32'h55);
        chk_tag_valid = 1'b1;
        chk_tag       = 8'd9;
        @(negedge clk);
        check("order_clear", 64'(chk_tag_clear), 64'd0);
        tick();
        chk_tag_valid = 1'b0;
        @(negedge clk);
        check("order_alert", 64'(alert), 64'd1);
        check("order_code", 64'(alert_code), 64'd2);
        check("order_pend_ready", 64'(pend_ready), 64'd0);
        tick();
        check("order_pend_ready_later", 64'(pend_ready), 64'd0);
        do_reset();

        // Fill with a held release, then drain
        rel_ready = 1'b0;
        nxt_push  = 8'h10;
        nxt_chk   = 8'h10;
        n_push    = 0;
        bad_clear = 0;
        saw_full  = 1'b0;
        for (int c = 0; c < 40 && !saw_full; c++) begin
            pend_valid    = 1'b1;
            pend_tag      = nxt_push;
            pend_data     = 32'h100 + 32'(nxt_push);
            chk_tag_valid = 1'b1;
            chk_tag       = nxt_chk;
            @(negedge clk);
            if (!pend_ready) saw_full = 1'b1;
            else begin
                nxt_push++;
                n_push++;
            end
            if (chk_tag_clear) begin
                if (rel_valid && !rel_ready) bad_clear++;
                nxt_chk++;
            end
            tick();
        end
        check("full_seen", 64'(saw_full), 64'd1);
        check("full_push_count", 64'(n_push), 64'(DEPTH + 1));
        check("full_held_clear", 64'(bad_clear), 64'd0);
        check("full_held_valid", 64'(rel_valid), 64'd1);
        pend_valid = 1'b0;
        rel_ready  = 1'b1;
        for (int c = 0; c < 100 && (sb.size() != 0); c++) begin
            chk_tag_valid = 1'b1;
            chk_tag       = nxt_chk;
            @(negedge clk);
            if (chk_tag_clear) nxt_chk++;
            tick();
        end
        chk_tag_valid = 1'b0;
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
        check("drain_chk_count", 64'(nxt_chk), 64'(8'h10 + DEPTH + 1));
        check("drain_alert", 64'(alert), 64'd0);
        do_reset();

        // Invalid beats a same-cycle match; held release still drains
        rel_ready = 1'b0;
        push_one(8'h20, 32'h200);
        push_one(8'h21, 32'h201);
        chk_tag_valid = 1'b1;
        chk_tag       = 8'h20;
        tick();
        chk_tag     = 8'h21;
        chk_invalid = 1'b1;
        rel_ready   = 1'b1;
        @(negedge clk);
        check("inv_rel_held", 64'(rel_valid), 64'd1);
        check("inv_clear", 64'(chk_tag_clear), 64'd0);
        tick();
        idle_inputs();
        @(negedge clk);
        check("inv_alert", 64'(alert), 64'd1);
        check("inv_code", 64'(alert_code), 64'd1);
        check("inv_drained", 64'(rel_valid), 64'd0);
        check("inv_one_left", 64'(sb.size()), 64'd1);
        do_reset();

        // Stall with no checked tags
        push_one(8'd3, 32'h33);
`ifdef SENTRY_RELEASE_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            check("to_no_alert_yet", 64'(alert), 64'd0);
            tick();
        end
        @(negedge clk);
        check("to_alert", 64'(alert), 64'd1);
        check("to_code", 64'(alert_code), 64'd3);
`else
        repeat (100) tick();
        @(negedge clk);
        check("to_off_alert", 64'(alert), 64'd0);
        check("to_off_code", 64'(alert_code), 64'd0);
`endif
        do_reset();

        // Asynchronous reset mid-operation
        rel_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_one(tag_t'(8'h30 + i), 32'h300 + 32'(i));
        chk_tag_valid = 1'b1;
        chk_tag       = 8'h30;
        tick();
        chk_tag_valid = 1'b0;
        @(negedge clk);
        check("arst_pre_valid", 64'(rel_valid), 64'd1);
        tick();
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        check("arst_rel_valid", 64'(rel_valid), 64'd0);
        check("arst_pend_ready", 64'(pend_ready), 64'd1);
        check("arst_alert", 64'(alert), 64'd0);
        tick();
        rst       = 1'b0;
        rel_ready = 1'b1;
        push_one(8'd1, 32'h1111);
        chk_tag_valid = 1'b1;
        chk_tag       = 8'd1;
        @(negedge clk);
        check("arst_clear", 64'(chk_tag_clear), 64'd1);
        tick();
        chk_tag_valid = 1'b0;
        @(negedge clk);
        check("arst_rel_valid_after", 64'(rel_valid), 64'd1);
        check("arst_rel_data", 64'(rel_data), 64'h1111);
        tick();
        check("arst_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
